// File: rtl/frv_gprs_param.sv
// frv_gprs_param: parametrised even/odd banked GPR file with optional write bypass,
// a post-reset clear engine and a registered flag for dropped odd-address wide writes.
module frv_gprs_param #(
   parameter int XLEN = 32,
   parameter int NREGS = 32,
   parameter int NRD = 3,
   parameter bit BYPASS = 1'b1,
   parameter bit CLEAR_ON_RESET = 1'b1,
   localparam int AW = $clog2(NREGS)
) (
   input  logic                g_clk,
   input  logic                g_reset,
   input  logic [NRD*AW-1:0]   rs_addr,
   output logic [NRD*XLEN-1:0] rs_data,
   input  logic                rd_wen,
   input  logic                rd_wide,
   input  logic [AW-1:0]       rd_addr,
   input  logic [XLEN-1:0]     rd_wdata,
   input  logic [XLEN-1:0]     rd_wdata_hi,
   output logic                clr_busy,
   output logic                wide_err
);
   localparam int HW = AW - 1;
   localparam logic [HW-1:0] LAST = HW'(NREGS / 2 - 1);
   typedef enum logic {S_IDLE, S_CLEAR} state_t;
   state_t r_state, w_state_nxt;
   logic [HW-1:0] r_idx, w_idx_nxt;
   logic [XLEN-1:0] r_even [NREGS/2];
   logic [XLEN-1:0] r_odd [NREGS/2];
   logic r_wide_err;
   logic w_idle, w_illegal, w_acc, w_we_e, w_we_o;
   logic [HW-1:0] w_top;
   logic [XLEN-1:0] w_odd_data;
   assign w_idle = (r_state == S_IDLE);
   assign w_top = rd_addr[AW-1:1];
   assign w_illegal = rd_wen & rd_wide & rd_addr[0] & w_idle;
   assign w_acc = rd_wen & w_idle & ~w_illegal;
   // x0 lives in even[0] and is never written; a wide write to 0 lands only in x1
   assign w_we_e = w_acc & ~rd_addr[0] & (w_top != '0);
   assign w_we_o = w_acc & (rd_addr[0] | rd_wide);
   assign w_odd_data = rd_wide ? rd_wdata_hi : rd_wdata;
   assign clr_busy = ~w_idle;
   assign wide_err = r_wide_err;
   always_ff @(posedge g_clk) begin
      if (g_reset) begin
         r_state <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
         r_idx <= '0;
         r_wide_err <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_idx <= w_idx_nxt;
         r_wide_err <= w_illegal;
      end
   end
   always_comb begin
      w_idx_nxt = (r_state == S_CLEAR) ? r_idx + 1'b1 : r_idx;
      w_state_nxt = (r_state == S_CLEAR && r_idx == LAST) ? S_IDLE : r_state;
   end
   always_ff @(posedge g_clk) begin
      if (r_state == S_CLEAR && !g_reset) begin
         r_even[r_idx] <= '0;
         r_odd[r_idx] <= '0;
      end else begin
         if (w_we_e) r_even[w_top] <= rd_wdata;
         if (w_we_o) r_odd[w_top] <= w_odd_data;
      end
   end
   for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [AW-1:0] w_a;
      logic w_hit_e, w_hit_o;
      assign w_a = rs_addr[i*AW +: AW];
      assign w_hit_e = BYPASS && w_we_e && (w_a == {w_top, 1'b0});
      assign w_hit_o = BYPASS && w_we_o && (w_a == {w_top, 1'b1});
      assign rs_data[i*XLEN +: XLEN] = (!w_idle || w_a == '0) ? '0 :
                                       w_hit_e ? rd_wdata :
                                       w_hit_o ? w_odd_data :
                                       w_a[0] ? r_odd[w_a[AW-1:1]] : r_even[w_a[AW-1:1]];
   end
endmodule

// File: tb/tb_frv_gprs_param.sv
// tb_frv_gprs_param: directed and random checks of three GPR file configurations
// (bypass, no bypass, 64-bit/16-reg/2-port) against a register-array reference model.
module tb_frv_gprs_param;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;
   logic [14:0] rsa;
   logic [95:0] rd_a, rd_b;
   logic wen, wide;
   logic [4:0] wa;
   logic [31:0] wd, wh;
   logic busy_a, busy_b, err_a, err_b;
   logic [7:0] rsc;
   logic [127:0] rd_c;
   logic wen_c, wide_c;
   logic [3:0] wa_c;
   logic [63:0] wd_c, wh_c;
   logic busy_c, err_c;

   frv_gprs_param u_a (.g_clk(clk), .g_reset(rst), .rs_addr(rsa), .rs_data(rd_a),
      .rd_wen(wen), .rd_wide(wide), .rd_addr(wa), .rd_wdata(wd), .rd_wdata_hi(wh),
      .clr_busy(busy_a), .wide_err(err_a));
   frv_gprs_param #(.BYPASS(1'b0)) u_b (.g_clk(clk), .g_reset(rst), .rs_addr(rsa), .rs_data(rd_b),
      .rd_wen(wen), .rd_wide(wide), .rd_addr(wa), .rd_wdata(wd), .rd_wdata_hi(wh),
      .clr_busy(busy_b), .wide_err(err_b));
   frv_gprs_param #(.XLEN(64), .NREGS(16), .NRD(2)) u_c (.g_clk(clk), .g_reset(rst),
      .rs_addr(rsc), .rs_data(rd_c), .rd_wen(wen_c), .rd_wide(wide_c), .rd_addr(wa_c),
      .rd_wdata(wd_c), .rd_wdata_hi(wh_c), .clr_busy(busy_c), .wide_err(err_c));

   logic [31:0] ma [32];
   logic [63:0] mc [16];
   int rem_a, rem_c;
   bit em_a, em_c;
   int n_chk, n_err;

   function automatic logic [63:0] exp_a(int a, bit byp);
      if (rem_a > 0 || a == 0) return 64'd0;
      if (byp && wen && !(wide && wa[0])) begin
         if (a == int'(wa)) return {32'd0, wd};
         if (wide && a == int'(wa) + 1) return {32'd0, wh};
      end
      return {32'd0, ma[a]};
   endfunction

   function automatic logic [63:0] exp_c(int a);
      if (rem_c > 0 || a == 0) return 64'd0;
      if (wen_c && !(wide_c && wa_c[0])) begin
         if (a == int'(wa_c)) return wd_c;
         if (wide_c && a == int'(wa_c) + 1) return wh_c;
      end
      return mc[a];
   endfunction

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_all();
      for (int p = 0; p < 3; p++) begin
         chk($sformatf("a_rd%0d_x%0d", p, rsa[p*5 +: 5]), {32'd0, rd_a[p*32 +: 32]}, exp_a(rsa[p*5 +: 5], 1'b1));
         chk($sformatf("b_rd%0d_x%0d", p, rsa[p*5 +: 5]), {32'd0, rd_b[p*32 +: 32]}, exp_a(rsa[p*5 +: 5], 1'b0));
      end
      for (int p = 0; p < 2; p++)
         chk($sformatf("c_rd%0d_x%0d", p, rsc[p*4 +: 4]), rd_c[p*64 +: 64], exp_c(rsc[p*4 +: 4]));
      chk("a_busy", 64'(busy_a), 64'(rem_a > 0));
      chk("b_busy", 64'(busy_b), 64'(rem_a > 0));
      chk("c_busy", 64'(busy_c), 64'(rem_c > 0));
      chk("a_err", 64'(err_a), 64'(em_a));
      chk("b_err", 64'(err_b), 64'(em_a));
      chk("c_err", 64'(err_c), 64'(em_c));
   endtask

   task automatic update();
      if (rst) begin
         rem_a = 16; rem_c = 8; em_a = 0; em_c = 0;
      end else begin
         em_a = wen && rem_a == 0 && wide && wa[0];
         if (wen && rem_a == 0 && !(wide && wa[0])) begin
            if (wa != 0) ma[wa] = wd;
            if (wide) ma[int'(wa) + 1] = wh;
         end
         if (rem_a > 0) begin
            rem_a--;
            if (rem_a == 0) foreach (ma[i]) ma[i] = '0;
         end
         em_c = wen_c && rem_c == 0 && wide_c && wa_c[0];
         if (wen_c && rem_c == 0 && !(wide_c && wa_c[0])) begin
            if (wa_c != 0) mc[wa_c] = wd_c;
            if (wide_c) mc[int'(wa_c) + 1] = wh_c;
         end
         if (rem_c > 0) begin
            rem_c--;
            if (rem_c == 0) foreach (mc[i]) mc[i] = '0;
         end
      end
   endtask

   task automatic cycle();
      #1;
      chk_all();
      @(posedge clk);
      update();
      @(negedge clk);
   endtask

   initial begin
      n_chk = 0; n_err = 0;
      rst = 1'b1; rsa = '0; wen = 0; wide = 0; wa = '0; wd = '0; wh = '0;
      rsc = '0; wen_c = 0; wide_c = 0; wa_c = '0; wd_c = '0; wh_c = '0;
      foreach (ma[i]) ma[i] = 'x;
      foreach (mc[i]) mc[i] = 'x;
      repeat (2) @(posedge clk);
      update();
      @(negedge clk);
      cycle();
      rst = 1'b0;
      // writes issued during the clear must be discarded
      for (int i = 0; i < 16; i++) begin
         wen = 1; wa = 5'(i + 2); wd = $urandom; rsa = {3{5'(i + 2)}};
         wen_c = 1; wa_c = 4'(i % 8 + 1); wd_c = {$urandom, $urandom}; rsc = {2{4'(i % 8 + 1)}};
         chk("busy_during_clear", 64'(busy_a), 64'd1);
         cycle();
      end
      wen = 0; wen_c = 0;
      chk("busy_after_16", 64'(busy_a), 64'd0);
      for (int r = 0; r < 32; r++) begin
         rsa = {3{5'(r)}}; rsc = {4'(r % 16), 4'((r + 1) % 16)};
         cycle();
      end
      wen = 1; wide = 0; wa = 5'd5; wd = 32'hDEADBEEF; rsa = {3{5'd5}};
      #1;
      chk("byp_x5_same", {32'd0, rd_a[31:0]}, 64'hDEADBEEF);
      chk("nobyp_x5_same", {32'd0, rd_b[95:64]}, 64'd0);
      cycle();
      wen = 0;
      #1;
      chk("b_x5_next", {32'd0, rd_b[63:32]}, 64'hDEADBEEF);
      cycle();
      wen = 1; wide = 1; wa = 5'd6; wd = 32'h11111111; wh = 32'h22222222; rsa = {5'd7, 5'd6, 5'd7};
      #1;
      chk("byp_x6", {32'd0, rd_a[63:32]}, 64'h11111111);
      chk("byp_x7", {32'd0, rd_a[31:0]}, 64'h22222222);
      cycle();
      wen = 0;
      cycle();
      wen = 1; wide = 1; wa = 5'd7; wd = 32'h33333333; wh = 32'h44444444; rsa = {5'd8, 5'd7, 5'd8};
      cycle();
      wa = 5'd7;
      #1;
      chk("err_first", 64'(err_a), 64'd1);
      cycle();
      wen = 0; wide = 0;
      #1;
      chk("err_second", 64'(err_a), 64'd1);
      chk("x7_kept", {32'd0, rd_a[63:32]}, 64'h22222222);
      cycle();
      chk("err_low", 64'(err_a), 64'd0);
      wen = 1; wa = 5'd0; wd = 32'hFFFFFFFF; rsa = '0;
      cycle();
      wide = 1; wd = 32'h5A5A5A5A; wh = 32'hA5A5A5A5; rsa = {5'd1, 5'd0, 5'd1};
      #1;
      chk("x0_no_byp", {32'd0, rd_a[36:5] & 32'h0}, 64'd0);
      chk("x0_rd", {32'd0, rd_a[63:32]}, 64'd0);
      cycle();
      wen = 0; wide = 0;
      #1;
      chk("x1_hi", {32'd0, rd_a[31:0]}, 64'hA5A5A5A5);
      cycle();
      wen_c = 1; wide_c = 1; wa_c = 4'd4; wd_c = 64'h0123456789ABCDEF; wh_c = 64'hFEDCBA9876543210;
      rsc = {4'd5, 4'd4};
      cycle();
      wen_c = 0; wide_c = 0;
      #1;
      chk("c_x4", rd_c[63:0], 64'h0123456789ABCDEF);
      chk("c_x5", rd_c[127:64], 64'hFEDCBA9876543210);
      cycle();
      rst = 1;
      cycle();
      rst = 0;
      repeat (9) cycle();
      rst = 1;
      cycle();
      rst = 0;
      for (int i = 0; i < 16; i++) begin
         chk("restart_busy", 64'(busy_a), 64'd1);
         cycle();
      end
      chk("restart_done", 64'(busy_a), 64'd0);
      for (int n = 0; n < 500; n++) begin
         rst = ($urandom % 200 == 0);
         wen = $urandom_range(0, 1); wide = ($urandom % 3 == 0); wa = 5'($urandom);
         wd = $urandom; wh = $urandom;
         for (int p = 0; p < 3; p++) begin
            int s = $urandom % 3;
            rsa[p*5 +: 5] = (s == 0) ? wa : (s == 1) ? 5'(wa + 1) : 5'($urandom);
         end
         wen_c = $urandom_range(0, 1); wide_c = ($urandom % 3 == 0); wa_c = 4'($urandom);
         wd_c = {$urandom, $urandom}; wh_c = {$urandom, $urandom};
         for (int p = 0; p < 2; p++) begin
            int s = $urandom % 3;
            rsc[p*4 +: 4] = (s == 0) ? wa_c : (s == 1) ? 4'(wa_c + 1) : 4'($urandom);
         end
         cycle();
      end
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/frv_gprs_param.md
# frv_gprs_param

Parametrised general purpose register file for the frv core: the next generation of the fixed 32x32 banked GPR file. XLEN, register count and read-port count are configurable, and the even/odd bank split for wide (register-pair) writes is retained. New features are an optional same-cycle write-to-read bypass, a sequential clear engine that zeroes the file after reset, and a registered error flag for illegal wide writes. It sits between decode (operand reads) and writeback (rd writes).

## Interface
- XLEN, 32, register width in bits.
- NREGS, 32, number of architectural registers; power of two, >= 4.
- NRD, 3, number of read ports.
- BYPASS, 1, 1 = a read of a register being written this cycle returns the new write data.
- CLEAR_ON_RESET, 1, 1 = zero every register after reset via the clear engine.
- AW (local), log2(NREGS), register address width.
- g_clk  in  1  clock; all state updates on the rising edge.
- g_reset  in  1  reset; synchronous, active-high.
- rs_addr  in  NRD*AW  read addresses; port i is at [i*AW +: AW].
- rs_data  out  NRD*XLEN  read data; port i is at [i*XLEN +: XLEN]; combinational.
- rd_wen  in  1  write enable.
- rd_wide  in  1  wide write: rd_wdata goes to rd_addr, rd_wdata_hi goes to rd_addr+1.
- rd_addr  in  AW  destination address.
- rd_wdata  in  XLEN  write data, low word.
- rd_wdata_hi  in  XLEN  write data, high word (wide writes only).
- clr_busy  out  1  clear engine active; writes are ignored while high.
- wide_err  out  1  one-cycle pulse, registered, flags a dropped illegal wide write.

## Operation
- Storage: two banks, even and odd, each NREGS/2 x XLEN. Register n is held in bank (n[0]), at index n[AW-1:1].
- Register x0 always reads 0. Writes to x0 are discarded. A wide write to rd_addr=0 writes only x1 (with rd_wdata_hi).
- A write is accepted when rd_wen=1, the clear engine is in IDLE, and the write is not an illegal wide write.
  - Narrow write: rd_wdata goes to rd_addr.
  - Wide write: rd_addr must be even. rd_wdata goes to even[top] and rd_wdata_hi goes to odd[top], in the same edge.
- Illegal wide write (rd_wen & rd_wide & rd_addr[0], in IDLE): the write is dropped entirely, and wide_err=1 in the following cycle.
- Bypass (BYPASS=1): when a write is accepted in a cycle, any read port whose address matches a written register (excluding x0) returns the write data. Wide writes forward both pair registers. With BYPASS=0, reads return the stored value only.
- Clear engine FSM (CLEAR_ON_RESET=1):
  - States: IDLE and CLEAR; a pair index idx is AW-1 bits wide.
  - g_reset=1 forces state=CLEAR and idx=0.
  - In CLEAR, each edge with g_reset=0 zeroes even[idx] and odd[idx], then increments idx.
  - The edge on which idx==NREGS/2-1 moves the FSM to IDLE.
  - clr_busy = (state==CLEAR). While busy, all rs_data read 0 and rd_wen is ignored (no wide_err either).
- CLEAR_ON_RESET=0: reset forces IDLE and clr_busy=0. Register contents are unspecified until written, apart from x0.
- Reset asserted mid-clear restarts the clear from idx=0.
- Reset values:
  - wide_err=0.
  - clr_busy=1 when CLEAR_ON_RESET=1, otherwise 0.
  - rs_data=0 while busy.

## Timing
- Reads are combinational from rs_addr (and from the write inputs when BYPASS=1). There are no read-port registers.
- A write accepted at edge k is visible on reads from cycle k+1. With BYPASS=1 it is also visible in the cycle before edge k.
- The clear takes exactly NREGS/2 edges after g_reset falls: 16 edges for NREGS=32. clr_busy falls after the last of these edges.
- wide_err is high for exactly one cycle per illegal request. Back-to-back illegal requests keep it high for consecutive cycles.
- Simultaneous read and write of the same register with BYPASS=0 returns the old value.

## Test plan
- Reset for 2 cycles then release (NREGS=32) -> clr_busy=1 for exactly 16 edges and then 0; afterwards all 32 registers read 0 on every port; writes issued while busy are not stored.
- Narrow write x5=0xDEADBEEF, then read x5 on all 3 ports -> next cycle 0xDEADBEEF; with BYPASS=1 the same-cycle read is also 0xDEADBEEF; with BYPASS=0 the same-cycle read shows the old value 0.
- Wide write rd_addr=6, lo=0x11111111, hi=0x22222222 -> x6=0x11111111 and x7=0x22222222 next cycle; with BYPASS=1 both are forwarded in the same cycle.
- Wide write rd_addr=7 -> x7 and x8 unchanged; wide_err=1 for one cycle; two consecutive illegal requests -> wide_err high for 2 cycles.
- Write x0=0xFFFFFFFF, and wide write rd_addr=0 with hi=0xA5A5A5A5 -> x0 reads 0 (no bypass either), x1=0xA5A5A5A5.
- Assert g_reset at idx=9 mid-clear -> clear restarts; clr_busy stays high for a further 16 edges after release; parameter sweep with XLEN=64, NREGS=16, NRD=2 -> clear takes 8 edges and full 64-bit data is read back correctly.
